// File: rtl/abs_diff_eval_pkg.sv
// Shared types and arithmetic helpers for the abs_diff approximate-circuit evaluator.
package abs_diff_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

    localparam int unsigned CALC_W = 32;

    function automatic logic [CALC_W-1:0] exact_abs_diff(input logic [CALC_W-1:0] a,
                                                         input logic [CALC_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Absolute error between exact and approximate results, clamped to out_w bits.
    function automatic logic [CALC_W-1:0] sat_abs_err(input logic [CALC_W-1:0] exact,
                                                      input logic [CALC_W-1:0] apx,
                                                      input int unsigned       out_w);
        logic [CALC_W-1:0] diff;
        logic [CALC_W-1:0] lim;
        diff = (exact >= apx) ? (exact - apx) : (apx - exact);
        lim  = (32'd1 << out_w) - 32'd1;
        return (diff > lim) ? lim : diff;
    endfunction

endpackage

// File: rtl/abs_diff_error_monitor_if.sv
// Bundle between the evaluator and the approximate circuit / controlling environment.
interface abs_diff_error_monitor_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3
);
    logic                    start_i;
    logic [IN_W-1:0]         vec_o;
    logic [OUT_W-1:0]        apx_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    pass_o;
    logic [OUT_W-1:0]        max_err_o;
    logic [IN_W:0]           viol_cnt_o;
    logic [OUT_W+IN_W-1:0]   err_sum_o;

    modport slave (
        input  start_i, apx_i,
        output vec_o, busy_o, done_o, pass_o, max_err_o, viol_cnt_o, err_sum_o
    );

    modport master (
        output start_i, apx_i,
        input  vec_o, busy_o, done_o, pass_o, max_err_o, viol_cnt_o, err_sum_o
    );
endinterface

// File: rtl/abs_diff_err_stage.sv
// Stage-2 error compute plus max / violation / sum accumulators.
// Optional feature macro: ABS_DIFF_ERR_SUM_EN builds the error-sum accumulator.
module abs_diff_err_stage
    import abs_diff_eval_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned ET    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_vld,
    input  logic [IN_W-1:0]       i_vec,
    input  logic [OUT_W-1:0]      i_apx,
    output logic [OUT_W-1:0]      o_max_err,
    output logic [OUT_W-1:0]      o_max_nxt,
    output logic [IN_W:0]         o_viol_cnt,
    output logic [OUT_W+IN_W-1:0] o_err_sum
);

    localparam int unsigned HALF_W = IN_W / 2;

    logic [HALF_W-1:0] w_a;
    logic [HALF_W-1:0] w_b;
    logic [HALF_W-1:0] w_exact_h;
    logic [OUT_W-1:0]  w_exact;
    logic [OUT_W-1:0]  w_err;
    logic              w_viol;
    logic              w_new_max;

    logic [OUT_W-1:0]  r_max_err;
    logic [IN_W:0]     r_viol_cnt;

    assign w_a       = i_vec[HALF_W-1:0];
    assign w_b       = i_vec[IN_W-1:HALF_W];
    assign w_exact_h = HALF_W'(exact_abs_diff(32'(w_a), 32'(w_b)));
    assign w_exact   = OUT_W'(w_exact_h);
    assign w_err     = OUT_W'(sat_abs_err(32'(w_exact), 32'(i_apx), OUT_W));
    assign w_viol    = (32'(w_err) > ET);
    assign w_new_max = i_vld && (w_err > r_max_err);

    // Look-ahead of the max register so the parent can grade pass/fail on the retiring edge.
    assign o_max_nxt  = i_clr ? '0 : (w_new_max ? w_err : r_max_err);
    assign o_max_err  = r_max_err;
    assign o_viol_cnt = r_viol_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_err  <= '0;
            r_viol_cnt <= '0;
        end else if (i_clr) begin
            r_max_err  <= '0;
            r_viol_cnt <= '0;
        end else if (i_vld) begin
            if (w_new_max) r_max_err <= w_err;
            if (w_viol)    r_viol_cnt <= r_viol_cnt + (IN_W+1)'(1);
        end
    end

`ifdef ABS_DIFF_ERR_SUM_EN
    logic [OUT_W+IN_W-1:0] r_err_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sum <= '0;
        end else if (i_clr) begin
            r_err_sum <= '0;
        end else if (i_vld) begin
            r_err_sum <= r_err_sum + (OUT_W+IN_W)'(w_err);
        end
    end

    assign o_err_sum = r_err_sum;
`else
    assign o_err_sum = '0;
`endif

endmodule

// File: rtl/abs_diff_error_monitor.sv
// Exhaustive-sweep error monitor for an approximate |a-b| circuit: FSM, vector counter, S1 register.
// Optional feature macro: ABS_DIFF_ERR_SUM_EN (error-sum accumulator, otherwise err_sum_o = 0).
module abs_diff_error_monitor
    import abs_diff_eval_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned ET    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    abs_diff_error_monitor_if.slave bus
);

    eval_state_t       r_state;
    eval_state_t       w_state_nxt;
    logic              w_clr;
    logic              w_last;
    logic              w_pass_nxt;

    logic [IN_W-1:0]   r_vec;
    logic              r_done;
    logic              r_pass;

    logic              r_vld_p1;
    logic [IN_W-1:0]   r_vec_p1;
    logic [OUT_W-1:0]  r_apx_p1;

    logic [OUT_W-1:0]  w_max_nxt;

    assign w_last = (r_vec == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    w_state_nxt = SWEEP;
                    w_clr       = 1'b1;
                end
            end
            SWEEP:   if (w_last) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_vld_p1 <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            if (w_clr)                 r_vec <= '0;
            else if (r_state == SWEEP) r_vec <= r_vec + IN_W'(1);
            r_vld_p1 <= (r_state == SWEEP);
            r_done   <= (r_state == DRAIN);
            if (w_clr)                 r_pass <= 1'b0;
            else if (r_state == DRAIN) r_pass <= w_pass_nxt;
        end
    end

    // Stage 1: capture the driven vector with its settled approximate result
    always_ff @(posedge clk) begin
        if (r_state == SWEEP) begin
            r_vec_p1 <= r_vec;
            r_apx_p1 <= bus.apx_i;
        end
    end

    // Stage 2: error compute and accumulation
    abs_diff_err_stage #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) u_err_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_vld      (r_vld_p1),
        .i_vec      (r_vec_p1),
        .i_apx      (r_apx_p1),
        .o_max_err  (bus.max_err_o),
        .o_max_nxt  (w_max_nxt),
        .o_viol_cnt (bus.viol_cnt_o),
        .o_err_sum  (bus.err_sum_o)
    );

    assign w_pass_nxt = (32'(w_max_nxt) <= ET);

    assign bus.vec_o  = r_vec;
    assign bus.busy_o = (r_state == SWEEP) || (r_state == DRAIN);
    assign bus.done_o = r_done;
    assign bus.pass_o = r_pass;

endmodule

// File: tb/tb_abs_diff_error_monitor.sv
// Directed bench for abs_diff_error_monitor (IN_W=4, OUT_W=3, ET=4) with hand-computed results.
module tb_abs_diff_error_monitor;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 3;
    localparam int unsigned ET    = 4;
`ifdef ABS_DIFF_ERR_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    int         n_vec;
    int         n_miss;

    abs_diff_error_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    abs_diff_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in approximate circuit: 0 = exact |a-b|, 1 = constant 3, 2 = constant 7
    logic [1:0] tb_a, tb_b;
    always_comb begin
        tb_a = bus.vec_o[1:0];
        tb_b = bus.vec_o[3:2];
        case (mode)
            2'd0:    bus.apx_i = {1'b0, (tb_a >= tb_b) ? (tb_a - tb_b) : (tb_b - tb_a)};
            2'd1:    bus.apx_i = 3'b011;
            default: bus.apx_i = 3'b111;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_vec"},  32'(bus.vec_o), 0);
        check_val({tag, "_busy"}, 32'(bus.busy_o), 0);
        check_val({tag, "_done"}, 32'(bus.done_o), 0);
        check_val({tag, "_pass"}, 32'(bus.pass_o), 0);
        check_val({tag, "_max"},  32'(bus.max_err_o), 0);
        check_val({tag, "_viol"}, 32'(bus.viol_cnt_o), 0);
        check_val({tag, "_sum"},  32'(bus.err_sum_o), 0);
    endtask

    // Start edge counts as cycle 1; done must be seen after cycle 18.
    task automatic run_sweep(input string tag, input logic [1:0] m, input int e_max,
                             input int e_viol, input int e_sum, input bit e_pass,
                             input bit hold_start);
        int cyc;
        int extra;
        mode = m;
        @(negedge clk);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) bus.start_i = 1'b0;
        cyc = 1;
        check_val({tag, "_busy_start"}, 32'(bus.busy_o), 1);
        check_val({tag, "_vec_start"},  32'(bus.vec_o), 0);
        check_val({tag, "_max_clr"},    32'(bus.max_err_o), 0);
        check_val({tag, "_viol_clr"},   32'(bus.viol_cnt_o), 0);
        while (!bus.done_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 6) check_val({tag, "_vec_mid"}, 32'(bus.vec_o), 5);
        end
        bus.start_i = 1'b0;
        check_val({tag, "_latency"}, 32'(cyc), 18);
        check_val({tag, "_busy_done"}, 32'(bus.busy_o), 0);
        check_val({tag, "_max"},  32'(bus.max_err_o), 32'(e_max));
        check_val({tag, "_viol"}, 32'(bus.viol_cnt_o), 32'(e_viol));
        check_val({tag, "_sum"},  32'(bus.err_sum_o), SUM_EN ? 32'(e_sum) : 0);
        check_val({tag, "_pass"}, 32'(bus.pass_o), 32'(e_pass));
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.done_o) extra++;
        end
        check_val({tag, "_done_once"}, 32'(extra), 0);
        check_val({tag, "_max_hold"},  32'(bus.max_err_o), 32'(e_max));
        check_val({tag, "_pass_hold"}, 32'(bus.pass_o), 32'(e_pass));
    endtask

    // |a-b| over all 2-bit pairs: 0 x4, 1 x6, 2 x4, 3 x2.
    // apx=3: err sum 12+12+4+0=28, max 3. apx=7: errs 7,6,5,4 -> sum 92, max 7, 14 exceed ET.
    initial begin
        n_vec        = 0;
        n_miss       = 0;
        mode         = 2'd0;
        bus.start_i  = 1'b0;
        rst_n        = 1'b0;
        #23;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep("exact",  2'd0, 0, 0,  0,  1'b1, 1'b0);
        run_sweep("const3", 2'd1, 3, 0,  28, 1'b1, 1'b0);
        run_sweep("const7", 2'd2, 7, 14, 92, 1'b0, 1'b0);

        // Asynchronous reset seven cycles into a sweep
        mode = 2'd1;
        @(negedge clk);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("midrst_idle_busy", 32'(bus.busy_o), 0);
        check_val("midrst_idle_vec",  32'(bus.vec_o), 0);

        run_sweep("after_rst", 2'd2, 7, 14, 92, 1'b0, 1'b0);
        run_sweep("held",      2'd0, 0, 0,  0,  1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
